// File: rtl/pop_sort_ctrl_pkg.sv
// pop_sort_ctrl shared types: FSM encoding and word-width defaults.
// Imported by the interface, the arbiter and the controller top.
package pop_sort_ctrl_pkg;

  localparam int POP_W_DEF = 600;
  localparam int OUT_W_DEF = 300;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

endpackage

// File: rtl/pop_sort_ctrl_if.sv
// Bundle between the requesters, the controller and PopSorter.
// master = controller side, slave = requesters plus sorter.
interface pop_sort_ctrl_if
  import pop_sort_ctrl_pkg::*;
#(
  parameter int POP_W = POP_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);

  logic [1:0]       req;
  logic [POP_W-1:0] req_pop0;
  logic [POP_W-1:0] req_pop1;
  logic [1:0]       grant;
  logic [1:0]       ack;
  logic [OUT_W-1:0] result;
  logic             sort_start;
  logic [POP_W-1:0] sort_in;
  logic             sort_done;
  logic [OUT_W-1:0] sort_sorted;
  logic             busy;
  logic             timeout_err;

  modport master (
    input  req, req_pop0, req_pop1,
    input  sort_done, sort_sorted,
    output grant, ack, result,
    output sort_start, sort_in,
    output busy, timeout_err
  );

  modport slave (
    output req, req_pop0, req_pop1,
    output sort_done, sort_sorted,
    input  grant, ack, result,
    input  sort_start, sort_in,
    input  busy, timeout_err
  );

endinterface

// File: rtl/pop_sort_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; only the last-grant bit is stored.
// After reset requester 0 wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] win
);

  logic last;

  // remember who was granted most recently
  always_ff @(posedge clk) begin
    if (reset)     last <= 1'b1;
    else if (take) last <= win[1];
  end

  // tie goes to whoever did not win last time
  always_comb begin
    win = 2'b00;
    unique case (1'b1)
      (req == 2'b11): win = last ? 2'b01 : 2'b10;
      (req == 2'b01): win = 2'b01;
      (req == 2'b10): win = 2'b10;
      default:        win = 2'b00;
    endcase
  end

endmodule

// File: rtl/pop_sort_ctrl.sv
// Shares one PopSorter between two requesters (IDLE/LAUNCH/WAIT/DELIVER).
// Define SORT_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYC cycles.
module pop_sort_ctrl
  import pop_sort_ctrl_pkg::*;
#(
  parameter int POP_W       = POP_W_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic reset,
  pop_sort_ctrl_if.master bus
);

  state_t           state, state_d;
  logic [1:0]       win, grant_q, ack_q;
  logic             ld, fin, upd, tmo, terr_q;
  logic [POP_W-1:0] sin_q;
  logic [OUT_W-1:0] res_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req),
    .take  (ld),
    .win   (win)
  );

`ifdef SORT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;

  // count cycles spent in WAIT, cleared elsewhere
  always_ff @(posedge clk) begin
    if (reset)                cnt <= '0;
    else if (state != S_WAIT) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign tmo = (state == S_WAIT) && !bus.sort_done &&
               (cnt == CW'(TIMEOUT_CYC - 1));

  // sticky abort flag
  always_ff @(posedge clk) begin
    if (reset) terr_q <= 1'b0;
    else       terr_q <= terr_q | tmo;
  end
`else
  assign tmo    = 1'b0;
  // no watchdog: flag is constant low
  assign terr_q = (TIMEOUT_CYC < 0);
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // next state and job strobes
  always_comb begin
    state_d = state;
    ld      = 1'b0;
    fin     = 1'b0;
    upd     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|bus.req) begin
          ld      = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.sort_done) begin
          state_d = S_DELIVER;
        end else if (tmo) begin
          fin     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DELIVER: begin
        fin     = 1'b1;
        upd     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // owner, ack pulse and data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= 2'b00;
      ack_q   <= 2'b00;
      sin_q   <= '0;
      res_q   <= '0;
    end else begin
      ack_q <= fin ? grant_q : 2'b00;
      if (ld) begin
        grant_q <= win;
        sin_q   <= win[1] ? bus.req_pop1 : bus.req_pop0;
      end else if (fin) begin
        grant_q <= 2'b00;
      end
      if (upd) res_q <= bus.sort_sorted;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.ack         = ack_q;
  assign bus.result      = res_q;
  assign bus.sort_start  = (state == S_LAUNCH);
  assign bus.sort_in     = sin_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.timeout_err = terr_q;

endmodule
